// File: rtl/panda_seq_pkg.sv
`default_nettype none
// ==========================================================================
// panda_seq_pkg: shared types and frame layout for the PandA sequencer. Rev 1.0
// ==========================================================================
package panda_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_WAIT   = 3'd2,
    ST_PHASE1 = 3'd3,
    ST_PHASE2 = 3'd4
  } seq_state_e;

  localparam int WORDS_PER_FRAME = 4;

  // Bit positions inside frame word 1
  localparam int MASK_LSB = 0;
  localparam int COND_LSB = 4;
  localparam int OUT1_LSB = 8;
  localparam int OUT2_LSB = 14;
  localparam int COND_W   = 4;
  localparam int OUT_W    = 6;

  function automatic logic [31:0] nz_to_one(input logic [31:0] v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/panda_seq_table.sv
`default_nettype none
// ==========================================================================
// panda_seq_table: frame RAM with auto-incrementing write pointer. Rev 1.0
// ==========================================================================
module panda_seq_table
  import panda_seq_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           start_i,
  input  logic                           wstb_i,
  input  logic [31:0]                    wdata_i,
  input  logic                           re_i,
  input  logic [AW-3:0]                  rframe_i,
  output logic [32*WORDS_PER_FRAME-1:0]  rdata_o
);

  localparam int FRAMES = DEPTH / WORDS_PER_FRAME;

  logic [AW:0] wptr_q;
  logic        we;

  // Pointer saturates at DEPTH so that overflowing writes are discarded
  assign we = wstb_i && !start_i && (wptr_q < (AW+1)'(DEPTH));

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wptr_q <= '0;
    end else if (start_i) begin
      wptr_q <= '0;
    end else if (we) begin
      wptr_q <= wptr_q + 1'b1;
    end
  end

  // One bank per word of a frame so a whole frame reads in a single clock
  for (genvar b = 0; b < WORDS_PER_FRAME; b++) begin : g_bank
    logic [31:0] mem [FRAMES];
    logic [31:0] rd_q;

    always_ff @(posedge clk_i) begin
      if (we && (wptr_q[1:0] == 2'(b))) begin
        mem[wptr_q[AW-1:2]] <= wdata_i;
      end
      if (re_i) begin
        rd_q <= mem[rframe_i];
      end
    end

    assign rdata_o[32*b +: 32] = rd_q;
  end

endmodule
`default_nettype wire

// File: rtl/panda_sequencer.sv
`default_nettype none
// ==========================================================================
// panda_sequencer: frame-table sequencer driving six bus bits. Rev 1.0
// ==========================================================================
module panda_sequencer
  import panda_seq_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        gate_i,
  input  logic        inpa_i,
  input  logic        inpb_i,
  input  logic        inpc_i,
  input  logic        inpd_i,
  output logic        outa_o,
  output logic        outb_o,
  output logic        outc_o,
  output logic        outd_o,
  output logic        oute_o,
  output logic        outf_o,
  output logic        active_o,
  input  logic [31:0] PRESCALE,
  input  logic        SOFT_GATE,
  input  logic        TABLE_START,
  input  logic [31:0] TABLE_DATA,
  input  logic        TABLE_WSTB,
  input  logic [31:0] TABLE_CYCLE,
  input  logic [15:0] TABLE_LENGTH,
  input  logic        TABLE_LENGTH_WSTB,
  output logic [31:0] CUR_FRAME,
  output logic [31:0] CUR_FCYCLE,
  output logic [31:0] CUR_TCYCLE
);

  seq_state_e        state_q, state_d;
  logic              gate_q, gate_prev_q, start_q;
  logic [15:0]       len_q;
  logic [OUT_W-1:0]  out_q, out_d;
  logic [31:0]       cur_frame_q, frame_d;
  logic [31:0]       cur_fcycle_q, fcycle_d;
  logic [31:0]       cur_tcycle_q, tcycle_d;
  logic [31:0]       presc_q, presc_d;
  logic [31:0]       ticks_q, ticks_d;

  logic [32*WORDS_PER_FRAME-1:0] rdata;
  logic [31:0]       w0, w1, w2, w3;
  logic [AW:0]       len_clamp;
  logic [AW-2:0]     frame_cnt;
  logic [COND_W-1:0] inp, mask, cond;
  logic [OUT_W-1:0]  out1, out2;
  logic [31:0]       ps_m1, len_m1, rep_eff;
  logic              gate_rise, gate_fall, tick, phase_done, cond_ok;
  logic              unused_bits;

  panda_seq_table #(.DEPTH(DEPTH), .AW(AW)) u_table (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .start_i  (TABLE_START),
    .wstb_i   (TABLE_WSTB),
    .wdata_i  (TABLE_DATA),
    .re_i     (state_q == ST_LOAD),
    .rframe_i ((AW-2)'(cur_frame_q - 32'd1)),
    .rdata_o  (rdata)
  );

  assign w0 = rdata[31:0];
  assign w1 = rdata[63:32];
  assign w2 = rdata[95:64];
  assign w3 = rdata[127:96];

  assign mask = w1[MASK_LSB +: COND_W];
  assign cond = w1[COND_LSB +: COND_W];
  assign out1 = w1[OUT1_LSB +: OUT_W];
  assign out2 = w1[OUT2_LSB +: OUT_W];
  assign inp  = {inpd_i, inpc_i, inpb_i, inpa_i};

  assign len_clamp   = (len_q > 16'(DEPTH)) ? (AW+1)'(DEPTH) : len_q[AW:0];
  assign frame_cnt   = len_clamp[AW:2];
  assign unused_bits = ^{len_clamp[1:0], w1[31:OUT2_LSB+OUT_W]};

  // Gate and table-start are sampled together so a coincident start can veto a run
  assign gate_rise  = gate_q & ~gate_prev_q;
  assign gate_fall  = ~gate_q & gate_prev_q;
  assign ps_m1      = nz_to_one(PRESCALE) - 32'd1;
  assign len_m1     = nz_to_one((state_q == ST_PHASE1) ? w2 : w3) - 32'd1;
  assign rep_eff    = nz_to_one(w0);
  assign tick       = (presc_q == ps_m1);
  assign phase_done = tick && (ticks_q == len_m1);
  assign cond_ok    = (((inp ^ cond) & mask) == '0);

  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    frame_d  = cur_frame_q;
    fcycle_d = cur_fcycle_q;
    tcycle_d = cur_tcycle_q;
    presc_d  = tick ? 32'd0 : presc_q + 32'd1;
    ticks_d  = ticks_q + {31'd0, tick};
    if ((state_q != ST_IDLE) && (start_q || gate_fall)) begin
      state_d = ST_IDLE;
      out_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          out_d = '0;
          if (gate_rise && !start_q && (frame_cnt != '0)) begin
            state_d  = ST_LOAD;
            frame_d  = 32'd1;
            fcycle_d = 32'd1;
            tcycle_d = 32'd1;
          end
        end
        ST_LOAD: begin
          out_d   = '0;
          state_d = ST_WAIT;
        end
        ST_WAIT: begin
          out_d = '0;
          if (cond_ok) begin
            state_d = ST_PHASE1;
            out_d   = out1;
            presc_d = '0;
            ticks_d = '0;
          end
        end
        ST_PHASE1: begin
          if (phase_done) begin
            state_d = ST_PHASE2;
            out_d   = out2;
            presc_d = '0;
            ticks_d = '0;
          end
        end
        ST_PHASE2: begin
          if (phase_done) begin
            presc_d = '0;
            ticks_d = '0;
            out_d   = '0;
            if (cur_fcycle_q < rep_eff) begin
              fcycle_d = cur_fcycle_q + 32'd1;
              state_d  = ST_PHASE1;
              out_d    = out1;
            end else if (cur_frame_q < 32'(frame_cnt)) begin
              frame_d  = cur_frame_q + 32'd1;
              fcycle_d = 32'd1;
              state_d  = ST_LOAD;
            end else if ((frame_cnt != '0) &&
                         ((TABLE_CYCLE == 32'd0) || (cur_tcycle_q < TABLE_CYCLE))) begin
              tcycle_d = cur_tcycle_q + 32'd1;
              frame_d  = 32'd1;
              fcycle_d = 32'd1;
              state_d  = ST_LOAD;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          out_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q      <= ST_IDLE;
      gate_q       <= 1'b0;
      gate_prev_q  <= 1'b0;
      start_q      <= 1'b0;
      len_q        <= '0;
      out_q        <= '0;
      cur_frame_q  <= '0;
      cur_fcycle_q <= '0;
      cur_tcycle_q <= '0;
      presc_q      <= '0;
      ticks_q      <= '0;
    end else begin
      state_q      <= state_d;
      gate_q       <= gate_i | SOFT_GATE;
      gate_prev_q  <= gate_q;
      start_q      <= TABLE_START;
      if (TABLE_LENGTH_WSTB) begin
        len_q <= TABLE_LENGTH;
      end
      out_q        <= out_d;
      cur_frame_q  <= frame_d;
      cur_fcycle_q <= fcycle_d;
      cur_tcycle_q <= tcycle_d;
      presc_q      <= presc_d;
      ticks_q      <= ticks_d;
    end
  end

  assign {outf_o, oute_o, outd_o, outc_o, outb_o, outa_o} = out_q;
  assign active_o   = (state_q != ST_IDLE);
  assign CUR_FRAME  = cur_frame_q;
  assign CUR_FCYCLE = cur_fcycle_q;
  assign CUR_TCYCLE = cur_tcycle_q;

endmodule
`default_nettype wire

// File: tb/tb_panda_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ==========================================================================
// tb_panda_sequencer: directed self-checking bench for panda_sequencer. Rev 1.0
// ==========================================================================
module tb_panda_sequencer;

  logic        clk_i = 1'b0, reset_i = 1'b0, gate_i = 1'b0;
  logic        inpa_i = 1'b0, inpb_i = 1'b0, inpc_i = 1'b0, inpd_i = 1'b0;
  logic        outa_o, outb_o, outc_o, outd_o, oute_o, outf_o, active_o;
  logic [31:0] PRESCALE = 32'd1, TABLE_DATA = '0, TABLE_CYCLE = 32'd1;
  logic        SOFT_GATE = 1'b0, TABLE_START = 1'b0, TABLE_WSTB = 1'b0, TABLE_LENGTH_WSTB = 1'b0;
  logic [15:0] TABLE_LENGTH = '0;
  logic [31:0] CUR_FRAME, CUR_FCYCLE, CUR_TCYCLE;
  wire  [5:0]  outs = {outf_o, oute_o, outd_o, outc_o, outb_o, outa_o};

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  panda_sequencer dut (
    .clk_i(clk_i), .reset_i(reset_i), .gate_i(gate_i),
    .inpa_i(inpa_i), .inpb_i(inpb_i), .inpc_i(inpc_i), .inpd_i(inpd_i),
    .outa_o(outa_o), .outb_o(outb_o), .outc_o(outc_o), .outd_o(outd_o),
    .oute_o(oute_o), .outf_o(outf_o), .active_o(active_o),
    .PRESCALE(PRESCALE), .SOFT_GATE(SOFT_GATE), .TABLE_START(TABLE_START),
    .TABLE_DATA(TABLE_DATA), .TABLE_WSTB(TABLE_WSTB), .TABLE_CYCLE(TABLE_CYCLE),
    .TABLE_LENGTH(TABLE_LENGTH), .TABLE_LENGTH_WSTB(TABLE_LENGTH_WSTB),
    .CUR_FRAME(CUR_FRAME), .CUR_FCYCLE(CUR_FCYCLE), .CUR_TCYCLE(CUR_TCYCLE)
  );

  typedef struct {
    logic        gate;
    logic [5:0]  out;
    logic        act;
    logic [31:0] frame;
    logic [31:0] tcyc;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [31:0] d);
    TABLE_DATA = d;
    TABLE_WSTB = 1'b1;
    step();
    TABLE_WSTB = 1'b0;
  endtask

  task automatic tstart();
    TABLE_START = 1'b1;
    step();
    TABLE_START = 1'b0;
    step();
  endtask

  task automatic set_len(input logic [15:0] n);
    TABLE_LENGTH = n;
    TABLE_LENGTH_WSTB = 1'b1;
    step();
    TABLE_LENGTH_WSTB = 1'b0;
  endtask

  task automatic frame(input logic [31:0] rep, input logic [31:0] w1,
                       input logic [31:0] l1, input logic [31:0] l2);
    wr(rep); wr(w1); wr(l1); wr(l2);
  endtask

  function automatic logic [31:0] mkw1(input logic [3:0] m, input logic [3:0] c,
                                       input logic [5:0] o1, input logic [5:0] o2);
    return {12'd0, o2, o1, c, m};
  endfunction

  initial begin
    vec_t vt[10];
    int   pulses, maxf1, maxf2, ca, cb;
    bit   seen, done, bad, hit;

    // Reset state
    step(); step();
    check("rst_outs", 32'(outs), 32'd0);
    check("rst_active", 32'(active_o), 32'd0);
    check("rst_frame", CUR_FRAME, 32'd0);
    check("rst_fcycle", CUR_FCYCLE, 32'd0);
    check("rst_tcycle", CUR_TCYCLE, 32'd0);
    reset_i = 1'b1;
    step();

    // Test 1: single frame, cycle-by-cycle vector table
    tstart();
    frame(32'd1, mkw1(4'h0, 4'h0, 6'h01, 6'h02), 32'd2, 32'd3);
    set_len(16'd4);
    PRESCALE = 32'd1;
    TABLE_CYCLE = 32'd1;
    step();
    vt[0] = '{1'b1, 6'h00, 1'b0, 32'd0, 32'd0};
    vt[1] = '{1'b1, 6'h00, 1'b1, 32'd1, 32'd1};
    vt[2] = '{1'b1, 6'h00, 1'b1, 32'd1, 32'd1};
    vt[3] = '{1'b1, 6'h01, 1'b1, 32'd1, 32'd1};
    vt[4] = '{1'b1, 6'h01, 1'b1, 32'd1, 32'd1};
    vt[5] = '{1'b1, 6'h02, 1'b1, 32'd1, 32'd1};
    vt[6] = '{1'b1, 6'h02, 1'b1, 32'd1, 32'd1};
    vt[7] = '{1'b1, 6'h02, 1'b1, 32'd1, 32'd1};
    vt[8] = '{1'b1, 6'h00, 1'b0, 32'd1, 32'd1};
    vt[9] = '{1'b1, 6'h00, 1'b0, 32'd1, 32'd1};
    for (int i = 0; i < 10; i++) begin
      SOFT_GATE = vt[i].gate;
      step();
      check($sformatf("t1_out[%0d]", i), 32'(outs), 32'(vt[i].out));
      check($sformatf("t1_active[%0d]", i), 32'(active_o), 32'(vt[i].act));
      check($sformatf("t1_frame[%0d]", i), CUR_FRAME, vt[i].frame);
      check($sformatf("t1_tcycle[%0d]", i), CUR_TCYCLE, vt[i].tcyc);
    end
    SOFT_GATE = 1'b0;
    step(); step();

    // Test 2: input condition holds the frame in WAIT
    tstart();
    frame(32'd1, mkw1(4'h1, 4'h1, 6'h04, 6'h08), 32'd1, 32'd1);
    set_len(16'd4);
    inpa_i = 1'b0;
    gate_i = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (outs != 6'h00) bad = 1'b1;
    end
    check("t2_wait_outs_zero", 32'(bad), 32'd0);
    check("t2_wait_active", 32'(active_o), 32'd1);
    inpa_i = 1'b1;
    step();
    check("t2_phase1", 32'(outs), 32'h04);
    step();
    check("t2_phase2", 32'(outs), 32'h08);
    step();
    check("t2_end_active", 32'(active_o), 32'd0);
    gate_i = 1'b0;
    inpa_i = 1'b0;
    step(); step();

    // Test 3: two frames with repeats, table cycled twice
    tstart();
    frame(32'd3, mkw1(4'h0, 4'h0, 6'h01, 6'h02), 32'd1, 32'd1);
    frame(32'd2, mkw1(4'h0, 4'h0, 6'h10, 6'h20), 32'd1, 32'd1);
    set_len(16'd8);
    TABLE_CYCLE = 32'd2;
    gate_i = 1'b1;
    seen = 1'b0; done = 1'b0; pulses = 0; maxf1 = 0; maxf2 = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      step();
      if (active_o) seen = 1'b1;
      if (outa_o || oute_o) pulses++;
      if (active_o && CUR_FRAME == 32'd1 && int'(CUR_FCYCLE) > maxf1) maxf1 = int'(CUR_FCYCLE);
      if (active_o && CUR_FRAME == 32'd2 && int'(CUR_FCYCLE) > maxf2) maxf2 = int'(CUR_FCYCLE);
      if (seen && !active_o) done = 1'b1;
    end
    if (!done) timeout("t3_run_end");
    check("t3_pulses", 32'(pulses), 32'd10);
    check("t3_fcycle_max_f1", 32'(maxf1), 32'd3);
    check("t3_fcycle_max_f2", 32'(maxf2), 32'd2);
    check("t3_tcycle", CUR_TCYCLE, 32'd2);
    check("t3_frame", CUR_FRAME, 32'd2);
    check("t3_fcycle", CUR_FCYCLE, 32'd2);
    check("t3_outs_idle", 32'(outs), 32'd0);
    gate_i = 1'b0;
    step(); step();

    // Test 4: prescaler stretches each tick to 5 clocks
    tstart();
    frame(32'd1, mkw1(4'h0, 4'h0, 6'h01, 6'h02), 32'd2, 32'd2);
    set_len(16'd4);
    PRESCALE = 32'd5;
    TABLE_CYCLE = 32'd1;
    gate_i = 1'b1;
    seen = 1'b0; done = 1'b0; ca = 0; cb = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      step();
      if (active_o) seen = 1'b1;
      if (outa_o) ca++;
      if (outb_o) cb++;
      if (seen && !active_o) done = 1'b1;
    end
    if (!done) timeout("t4_run_end");
    check("t4_phase1_clocks", 32'(ca), 32'd10);
    check("t4_phase2_clocks", 32'(cb), 32'd10);
    gate_i = 1'b0;
    PRESCALE = 32'd1;
    step(); step();

    // Test 5: gate drop mid-phase, restart, then TABLE_START abort
    tstart();
    frame(32'd1, mkw1(4'h0, 4'h0, 6'h01, 6'h02), 32'd3, 32'd3);
    frame(32'd1, mkw1(4'h0, 4'h0, 6'h10, 6'h20), 32'd3, 32'd3);
    set_len(16'd8);
    TABLE_CYCLE = 32'd0;
    gate_i = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      step();
      if (CUR_TCYCLE == 32'd2 && oute_o) hit = 1'b1;
    end
    if (!hit) timeout("t5_reach_pass2");
    gate_i = 1'b0;
    step(); step();
    check("t5_fall_outs", 32'(outs), 32'd0);
    check("t5_fall_active", 32'(active_o), 32'd0);
    check("t5_hold_frame", CUR_FRAME, 32'd2);
    check("t5_hold_fcycle", CUR_FCYCLE, 32'd1);
    check("t5_hold_tcycle", CUR_TCYCLE, 32'd2);
    for (int i = 0; i < 5; i++) step();
    check("t5_hold_frame_later", CUR_FRAME, 32'd2);
    gate_i = 1'b1;
    step(); step();
    check("t5_restart_active", 32'(active_o), 32'd1);
    check("t5_restart_frame", CUR_FRAME, 32'd1);
    check("t5_restart_tcycle", CUR_TCYCLE, 32'd1);
    TABLE_START = 1'b1;
    step();
    TABLE_START = 1'b0;
    step();
    check("t5_tstart_active", 32'(active_o), 32'd0);
    check("t5_tstart_outs", 32'(outs), 32'd0);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (active_o) bad = 1'b1;
    end
    check("t5_no_restart_while_high", 32'(bad), 32'd0);
    gate_i = 1'b0;
    step(); step();

    // Test 6: short tables never start; coincident start vetoes a run
    for (int k = 0; k < 2; k++) begin
      set_len((k == 0) ? 16'd3 : 16'd0);
      gate_i = 1'b1;
      bad = 1'b0;
      for (int i = 0; i < 8; i++) begin
        step();
        if (active_o) bad = 1'b1;
      end
      check($sformatf("t6_len_short[%0d]", k), 32'(bad), 32'd0);
      gate_i = 1'b0;
      step(); step();
    end
    set_len(16'd8);
    gate_i = 1'b1;
    TABLE_START = 1'b1;
    step();
    TABLE_START = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (active_o) bad = 1'b1;
    end
    check("t6_start_beats_gate", 32'(bad), 32'd0);
    gate_i = 1'b0;
    step(); step();

    // Reset asserted mid-run clears everything without a clock
    gate_i = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      step();
      if (outs != 6'h00) hit = 1'b1;
    end
    if (!hit) timeout("t6_reach_run");
    #2;
    reset_i = 1'b0;
    #1;
    check("t6_rst_outs", 32'(outs), 32'd0);
    check("t6_rst_active", 32'(active_o), 32'd0);
    check("t6_rst_frame", CUR_FRAME, 32'd0);
    gate_i = 1'b0;
    step();
    reset_i = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
